gpio_controller: RTL and testbench

Memory-mapped general-purpose I/O peripheral occupying the 6-byte window at 0xF000_0000–0xF000_0005, directly downstream of the address decoder. It takes the decoder's GPIO write enable as its write strobe, and its read data is what the decoder's output select value 3'b001 routes back to the core. It drives per-pin output value and output enable, synchronises the input pins, and latches per-pin rising/falling-edge events into write-1-to-clear pending flags that produce a level interrupt.

---
 rtl/gpio_controller.sv | 112 +++++++++++
 tb/tb_gpio_controller.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_controller.sv
// Memory-mapped GPIO peripheral: output/direction registers, synchronised inputs,
// and edge-triggered write-1-to-clear pending flags driving a level interrupt.
module gpio_controller #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [2:0]       a,
    input  logic [7:0]       wd,
    output logic [7:0]       rd,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    typedef enum logic [2:0] {
        REG_OUT     = 3'd0,
        REG_DIR     = 3'd1,
        REG_IN      = 3'd2,
        REG_RISE_EN = 3'd3,
        REG_FALL_EN = 3'd4,
        REG_PEND    = 3'd5
    } reg_addr_e;

    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [WIDTH-1:0] s1_q, s1_d;
    logic [WIDTH-1:0] s2_q, s2_d;
    logic [WIDTH-1:0] prev_q, prev_d;

    logic [WIDTH-1:0] wd_bits;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] clr;

    assign wd_bits = wd[WIDTH-1:0];
    assign rise    = s2_q & ~prev_q;
    assign fall    = ~s2_q & prev_q;

    // NOTE: every always_comb output is given its hold value first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        out_d     = out_q;
        dir_d     = dir_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        clr       = '0;

        s1_d   = gpio_in;
        s2_d   = s1_q;
        prev_d = s2_q;

        if (we) begin
            case (a)
                REG_OUT:     out_d     = wd_bits;
                REG_DIR:     dir_d     = wd_bits;
                REG_RISE_EN: rise_en_d = wd_bits;
                REG_FALL_EN: fall_en_d = wd_bits;
                REG_PEND:    clr       = wd_bits;
                default:     ;
            endcase
        end

        // A new edge is OR-ed in after the clear, so a same-cycle event keeps its bit set.
        pend_d = (pend_q & ~clr) | (rise & rise_en_q) | (fall & fall_en_q);
    end

    always_comb begin
        rd = '0;
        case (a)
            REG_OUT:     rd[WIDTH-1:0] = out_q;
            REG_DIR:     rd[WIDTH-1:0] = dir_q;
            REG_IN:      rd[WIDTH-1:0] = s2_q;
            REG_RISE_EN: rd[WIDTH-1:0] = rise_en_q;
            REG_FALL_EN: rd[WIDTH-1:0] = fall_en_q;
            REG_PEND:    rd[WIDTH-1:0] = pend_q;
            default:     rd = '0;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q     <= '0;
            dir_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            pend_q    <= '0;
            s1_q      <= '0;
            s2_q      <= '0;
            prev_q    <= '0;
        end else begin
            out_q     <= out_d;
            dir_q     <= dir_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            pend_q    <= pend_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            prev_q    <= prev_d;
        end
    end

    assign gpio_out = out_q;
    assign gpio_oe  = dir_q;
    assign irq      = |pend_q;

endmodule

// File: tb/tb_gpio_controller.sv
// Scoreboard bench for gpio_controller: a driver pushes expected outputs from a
// register/sample-history model, a negedge monitor pops and compares them.
module tb_gpio_controller;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         we = 1'b0;
    logic [2:0]   a = '0;
    logic [7:0]   wd = '0;
    logic [7:0]   rd;
    logic [W-1:0] gpio_in = '0;
    logic [W-1:0] gpio_out;
    logic [W-1:0] gpio_oe;
    logic         irq;

    gpio_controller #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .we       (we),
        .a        (a),
        .wd       (wd),
        .rd       (rd),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .gpio_oe  (gpio_oe),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        bit           chk_rd;
        logic [7:0]   rd;
        bit           chk_pins;
        logic [W-1:0] out;
        logic [W-1:0] oe;
        bit           chk_irq;
        logic         irq;
    } exp_t;

    exp_t sb[$];
    exp_t dir_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: register file plus history of pin samples (newest first).
    logic [7:0]   m_reg[8];
    logic [W-1:0] m_hist[$];
    logic [W-1:0] pins;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) m_reg[i] = '0;
        m_hist = {W'(0), W'(0), W'(0)};
    endfunction

    // Rules: IN shows the pin as sampled one edge before the latest; an edge event is
    // the change between the two samples before that; events set PEND, W1C clears.
    function automatic void model_edge(input bit rst, input bit w, input logic [2:0] ad,
                                       input logic [7:0] d, input logic [W-1:0] p);
        logic [W-1:0] rise_ev, fall_ev, clr, pend;
        if (rst) begin
            model_reset();
            return;
        end
        rise_ev = m_hist[1] & ~m_hist[2];
        fall_ev = ~m_hist[1] & m_hist[2];
        clr     = (w && ad == 3'd5) ? d[W-1:0] : '0;
        pend    = (m_reg[5][W-1:0] & ~clr) | (rise_ev & m_reg[3][W-1:0])
                | (fall_ev & m_reg[4][W-1:0]);
        if (w && (ad == 3'd0 || ad == 3'd1 || ad == 3'd3 || ad == 3'd4))
            m_reg[ad] = 8'(d[W-1:0]);
        m_reg[5] = 8'(pend);
        m_hist.push_front(p);
        void'(m_hist.pop_back());
    endfunction

    function automatic logic [7:0] model_rd(input logic [2:0] ad);
        case (ad)
            3'd2:       return 8'(m_hist[1]);
            3'd6, 3'd7: return 8'h00;
            default:    return m_reg[ad];
        endcase
    endfunction

    function automatic void expect_rd(input string name, input logic [7:0] r, input logic i);
        exp_t e;
        e.name = name; e.chk_rd = 1'b1; e.rd = r; e.chk_pins = 1'b0;
        e.out = '0; e.oe = '0; e.chk_irq = 1'b1; e.irq = i;
        dir_q.push_back(e);
    endfunction

    function automatic void expect_pins(input string name, input logic [W-1:0] o, input logic [W-1:0] oe);
        exp_t e;
        e.name = name; e.chk_rd = 1'b0; e.rd = '0; e.chk_pins = 1'b1;
        e.out = o; e.oe = oe; e.chk_irq = 1'b0; e.irq = 1'b0;
        dir_q.push_back(e);
    endfunction

    task automatic step(input bit rst, input bit w, input logic [2:0] ad,
                        input logic [7:0] d, input logic [W-1:0] p);
        exp_t e;
        reset = rst; we = w; a = ad; wd = d; gpio_in = p;
        @(posedge clk);
        model_edge(rst, w, ad, d, p);
        #1;
        we = 1'b0; reset = 1'b0;
        e.name = "model"; e.chk_rd = 1'b1; e.rd = model_rd(ad);
        e.chk_pins = 1'b1; e.out = m_reg[0][W-1:0]; e.oe = m_reg[1][W-1:0];
        e.chk_irq = 1'b1; e.irq = |m_reg[5];
        sb.push_back(e);
        while (dir_q.size() > 0) sb.push_back(dir_q.pop_front());
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] ad, input logic [7:0] d);
        step(1'b0, 1'b1, ad, d, pins);
    endtask

    task automatic rdreg(input logic [2:0] ad);
        step(1'b0, 1'b0, ad, 8'h00, pins);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.chk_rd)   check({e.name, " rd"}, 32'(rd), 32'(e.rd));
                if (e.chk_pins) check({e.name, " gpio_out"}, 32'(gpio_out), 32'(e.out));
                if (e.chk_pins) check({e.name, " gpio_oe"}, 32'(gpio_oe), 32'(e.oe));
                if (e.chk_irq)  check({e.name, " irq"}, 32'(irq), 32'(e.irq));
            end
        end
    end

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        model_reset();
        pins = '0;
        step(1'b1, 1'b0, 3'd0, 8'h00, pins);

        // Reset clears everything; a write during the reset cycle is dropped.
        for (int i = 0; i < 6; i++) wr(3'($urandom_range(0, 7)), 8'($urandom));
        expect_rd("rst_out_rd", 8'h00, 1'b0);
        expect_pins("rst_pins", '0, '0);
        step(1'b1, 1'b1, 3'd0, 8'hFF, pins);
        for (int i = 0; i < 8; i++) begin
            expect_rd($sformatf("rst_rd%0d", i), 8'h00, 1'b0);
            rdreg(3'(i));
        end

        // Output path.
        expect_pins("dir_write", '0, W'(8'hF0));
        wr(3'd1, 8'hF0);
        expect_pins("out_write", W'(8'hA5), W'(8'hF0));
        wr(3'd0, 8'hA5);
        expect_rd("out_readback", 8'hA5, 1'b0);
        rdreg(3'd0);
        expect_rd("dir_readback", 8'hF0, 1'b0);
        rdreg(3'd1);
        wr(3'd2, 8'hFF);
        expect_rd("in_ro", 8'h00, 1'b0);
        rdreg(3'd2);
        expect_rd("rsvd6", 8'h00, 1'b0);
        rdreg(3'd6);
        expect_rd("rsvd7", 8'h00, 1'b0);
        rdreg(3'd7);

        // Input latency on pin 0.
        wr(3'd3, 8'h01);
        pins = W'(8'h01);
        expect_rd("lat_k_in", 8'h00, 1'b0);
        rdreg(3'd2);
        expect_rd("lat_k1_in", 8'h01, 1'b0);
        rdreg(3'd2);
        expect_rd("lat_k2_pend", 8'h01, 1'b1);
        rdreg(3'd5);

        // Falling-edge-only capture on pin 3.
        wr(3'd3, 8'h00);
        wr(3'd4, 8'h08);
        wr(3'd5, 8'hFF);
        pins = W'(8'h09);
        for (int i = 0; i < 4; i++) rdreg(3'd5);
        expect_rd("fall_rise_ignored", 8'h00, 1'b0);
        rdreg(3'd5);
        pins = W'(8'h01);
        rdreg(3'd5);
        rdreg(3'd5);
        expect_rd("fall_pend", 8'h08, 1'b1);
        rdreg(3'd5);

        // W1C and set-wins collision.
        wr(3'd5, 8'hFF);
        wr(3'd4, 8'h00);
        wr(3'd3, 8'h03);
        pins = W'(8'h00);
        for (int i = 0; i < 3; i++) rdreg(3'd5);
        pins = W'(8'h03);
        rdreg(3'd5);
        rdreg(3'd5);
        expect_rd("w1c_pend03", 8'h03, 1'b1);
        rdreg(3'd5);
        expect_rd("w1c_one", 8'h02, 1'b1);
        wr(3'd5, 8'h01);
        pins = W'(8'h01);
        for (int i = 0; i < 3; i++) rdreg(3'd5);
        pins = W'(8'h03);
        rdreg(3'd5);
        rdreg(3'd5);
        expect_rd("w1c_collide", 8'h02, 1'b1);
        wr(3'd5, 8'h02);
        expect_rd("w1c_clear", 8'h00, 1'b0);
        wr(3'd5, 8'h02);

        // Reset during an in-flight edge.
        wr(3'd3, 8'hFF);
        wr(3'd4, 8'hFF);
        pins = W'(8'h07);
        rdreg(3'd5);
        expect_rd("rst_mid", 8'h00, 1'b0);
        expect_pins("rst_mid_pins", '0, '0);
        step(1'b1, 1'b0, 3'd5, 8'h00, pins);
        rdreg(3'd5);
        rdreg(3'd5);
        expect_rd("rst_mid_nospur", 8'h00, 1'b0);
        rdreg(3'd5);
        expect_rd("rst_mid_in", 8'h07, 1'b0);
        rdreg(3'd2);

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) pins = W'($urandom);
            step(($urandom_range(0, 49) == 0), 1'($urandom), 3'($urandom), 8'($urandom), pins);
        end

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
